glitc_intercom_cmd_sequencer: RTL

//  Link-level command sequencer directly upstream of the intercom command map. It

---
 rtl/glitc_intercom_cmd_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/glitc_intercom_cmd_sequencer.sv
// Link command sequencer: per-slot fixed-priority choice of SYNC > PING > PONG > TRAIN, plus ping round-trip timing.
// Commands are registered on the slot_i edge (1-cycle latency). No backpressure: requests wait in pending flags.
module glitc_intercom_cmd_sequencer #(
    parameter int SYNC_INTERVAL = 1024,
    parameter int TRAIN_SLOTS   = 64,
    parameter int PING_TIMEOUT  = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       slot_i,
    input  logic       train_req_i,
    input  logic       ping_req_i,
    input  logic       ping_rcvd_i,
    input  logic       pong_rcvd_i,
    output logic       sync_o,
    output logic       ping_o,
    output logic       pong_o,
    output logic       train_o,
    output logic       busy_o,
    output logic       ping_ok_o,
    output logic       ping_timeout_o,
    output logic [7:0] latency_o
);

    localparam int SCW = (SYNC_INTERVAL > 2) ? $clog2(SYNC_INTERVAL) : 1;
    localparam logic [SCW-1:0] SYNC_LAST  = SCW'(SYNC_INTERVAL - 1);
    localparam logic [7:0]     TRAIN_LOAD = 8'(TRAIN_SLOTS);
    localparam logic [7:0]     TO_LAST    = 8'(PING_TIMEOUT - 1);

    typedef enum logic {
        PING_IDLE = 1'b0,
        PING_WAIT = 1'b1
    } ping_state_t;

    ping_state_t    r_ping_state;
    logic [SCW-1:0] r_sync_cnt;
    logic           r_sync_pend;
    logic           r_ping_pend;
    logic           r_pong_pend;
    logic [7:0]     r_train_cnt;
    logic [7:0]     r_lat_cnt;
    logic           r_sync;
    logic           r_ping;
    logic           r_pong;
    logic           r_train;
    logic           r_ping_ok;
    logic           r_ping_timeout;
    logic [7:0]     r_latency;

    logic       w_sync_wrap;
    logic       w_sync_elig;
    logic       w_train_elig;
    logic       w_gnt_sync;
    logic       w_gnt_ping;
    logic       w_gnt_pong;
    logic       w_gnt_train;
    logic       w_ping_accept;
    logic       w_timeout;
    logic [7:0] w_lat_step;

    // The slot on which the counter wraps carries its own SYNC, keeping the period at exactly SYNC_INTERVAL slots.
    assign w_sync_wrap  = slot_i && (r_sync_cnt == SYNC_LAST);
    assign w_sync_elig  = r_sync_pend | w_sync_wrap;
    assign w_train_elig = (r_train_cnt != 8'd0);

    assign w_gnt_sync  = slot_i & w_sync_elig;
    assign w_gnt_ping  = slot_i & ~w_sync_elig & r_ping_pend;
    assign w_gnt_pong  = slot_i & ~w_sync_elig & ~r_ping_pend & r_pong_pend;
    assign w_gnt_train = slot_i & ~w_sync_elig & ~r_ping_pend & ~r_pong_pend & w_train_elig;

    assign w_ping_accept = ping_req_i & ~r_ping_pend & (r_ping_state == PING_IDLE);

    // A PONG landing on a slot edge counts that slot, so the reported latency matches the timeout threshold.
    assign w_lat_step = r_lat_cnt + {7'd0, slot_i};
    assign w_timeout  = (r_ping_state == PING_WAIT) & slot_i & ~pong_rcvd_i & (r_lat_cnt == TO_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ping_state   <= PING_IDLE;
            r_sync_cnt     <= '0;
            r_sync_pend    <= 1'b0;
            r_ping_pend    <= 1'b0;
            r_pong_pend    <= 1'b0;
            r_train_cnt    <= 8'd0;
            r_lat_cnt      <= 8'd0;
            r_sync         <= 1'b0;
            r_ping         <= 1'b0;
            r_pong         <= 1'b0;
            r_train        <= 1'b0;
            r_ping_ok      <= 1'b0;
            r_ping_timeout <= 1'b0;
            r_latency      <= 8'd0;
        end else begin
            r_ping_ok      <= 1'b0;
            r_ping_timeout <= 1'b0;

            if (slot_i) begin
                r_sync     <= w_gnt_sync;
                r_ping     <= w_gnt_ping;
                r_pong     <= w_gnt_pong;
                r_train    <= w_gnt_train;
                r_sync_cnt <= w_sync_wrap ? '0 : r_sync_cnt + 1'b1;
            end

            r_sync_pend <= w_sync_elig & ~w_gnt_sync;

            if (w_gnt_ping) begin
                r_ping_pend <= 1'b0;
            end else if (w_ping_accept) begin
                r_ping_pend <= 1'b1;
            end

            r_pong_pend <= (r_pong_pend & ~w_gnt_pong) | ping_rcvd_i;

            if (train_req_i) begin
                r_train_cnt <= TRAIN_LOAD;
            end else if (w_gnt_train) begin
                r_train_cnt <= r_train_cnt - 8'd1;
            end

            case (r_ping_state)
                PING_IDLE: begin
                    if (w_gnt_ping) begin
                        r_ping_state <= PING_WAIT;
                        r_lat_cnt    <= 8'd0;
                    end
                end
                PING_WAIT: begin
                    if (pong_rcvd_i) begin
                        r_latency    <= w_lat_step;
                        r_ping_ok    <= 1'b1;
                        r_ping_state <= PING_IDLE;
                    end else if (w_timeout) begin
                        r_ping_timeout <= 1'b1;
                        r_ping_state   <= PING_IDLE;
                    end else if (slot_i) begin
                        r_lat_cnt <= r_lat_cnt + 8'd1;
                    end
                end
                default: r_ping_state <= PING_IDLE;
            endcase
        end
    end

    assign sync_o         = r_sync;
    assign ping_o         = r_ping;
    assign pong_o         = r_pong;
    assign train_o        = r_train;
    assign ping_ok_o      = r_ping_ok;
    assign ping_timeout_o = r_ping_timeout;
    assign latency_o      = r_latency;
    assign busy_o         = r_sync_pend | r_ping_pend | r_pong_pend | w_train_elig
                          | (r_ping_state == PING_WAIT);

endmodule
